// File: rtl/hash_table_pkg.sv
// hash_table_pkg: shared types for the hash-table pipeline.
//   ht_pdata_t      - command travelling down the pipeline (bucket, head pointer)
//   head_ram_data_t - one head-table word {ptr, val}
//   ht_attach_head  - returns a command with the head-table word attached
package hash_table_pkg;

    localparam int BUCKET_WIDTH   = 4;
    localparam int HEAD_PTR_WIDTH = 8;
    localparam int KEY_WIDTH      = 16;

    typedef enum logic [1:0] {
        HT_CMD_SEARCH = 2'd0,
        HT_CMD_INSERT = 2'd1,
        HT_CMD_DELETE = 2'd2,
        HT_CMD_NOP    = 2'd3
    } ht_cmd_e;

    typedef struct packed {
        ht_cmd_e                   cmd;
        logic [KEY_WIDTH-1:0]      key;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                      head_ptr_val;
    } ht_pdata_t;

    typedef struct packed {
        logic [HEAD_PTR_WIDTH-1:0] ptr;
        logic                      val;
    } head_ram_data_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ht_state_e;

    function automatic ht_pdata_t ht_attach_head(input ht_pdata_t p, input head_ram_data_t h);
        ht_pdata_t r;
        r              = p;
        r.head_ptr     = h.ptr;
        r.head_ptr_val = h.val;
        return r;
    endfunction

endpackage

// File: rtl/head_table_ram.sv
// head_table_ram: simple dual-port head-table RAM, 2^BUCKET_WIDTH words.
//   clk_i      - clock
//   wr_en_i    - write strobe
//   wr_addr_i  - write address
//   wr_data_i  - write data {ptr, val}
//   rd_addr_i  - read address, sampled every cycle
//   rd_data_o  - registered read data, one cycle after rd_addr_i
// A read and write to the same address in one cycle returns the old word;
// the caller forwards the new word itself.
module head_table_ram
    import hash_table_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    wr_en_i,
    input  logic [BUCKET_WIDTH-1:0] wr_addr_i,
    input  head_ram_data_t          wr_data_i,
    input  logic [BUCKET_WIDTH-1:0] rd_addr_i,
    output head_ram_data_t          rd_data_o
);

    localparam int DEPTH = 1 << BUCKET_WIDTH;

    head_ram_data_t mem_q [DEPTH];
    head_ram_data_t rd_data_d;
    head_ram_data_t rd_data_q;

    always_comb begin
        rd_data_d = mem_q[rd_addr_i];
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/head_table.sv
// head_table: reads the bucket head pointer for each command and attaches it.
//   clk_i / rst_i        - clock, synchronous active-high reset
//   pdata_in_*           - command in (valid/ready), bucket field valid
//   pdata_out_*          - command out (valid/ready) with head_ptr/head_ptr_val
//   head_wr_*            - head-table update port from insert/delete logic
//   init_done_o          - table cleared and accepting commands
// Latency is 2 cycles: RAM read, then register into the skid buffer.
// Updates are forwarded to the RAM-stage read and to buffered commands, so an
// emitted head pointer always reflects every write made before it is shown.
// Build option HT_HEAD_TABLE_INIT_EN: sweep the table to zero after reset;
// otherwise the RAM relies on power-up zero and RUN starts right away.
module head_table
    import hash_table_pkg::*;
#(
    parameter int SKID_DEPTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  ht_pdata_t                 pdata_in_i,
    input  logic                      pdata_in_valid_i,
    output logic                      pdata_in_ready_o,
    output ht_pdata_t                 pdata_out_o,
    output logic                      pdata_out_valid_o,
    input  logic                      pdata_out_ready_i,
    input  logic                      head_wr_en_i,
    input  logic [BUCKET_WIDTH-1:0]   head_wr_addr_i,
    input  logic [HEAD_PTR_WIDTH-1:0] head_wr_ptr_i,
    input  logic                      head_wr_ptr_val_i,
    output logic                      init_done_o
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    ht_state_e state_q, state_d;
`ifdef HT_HEAD_TABLE_INIT_EN
    logic [BUCKET_WIDTH-1:0] init_cnt_q, init_cnt_d;
`endif

    // RAM stage: command whose head word is being read this cycle
    logic           s1_vld_q, s1_vld_d;
    ht_pdata_t      s1_pdata_q, s1_pdata_d;
    // write that hit the read address in the issue cycle (RAM returns old data)
    logic           fwd_hit_q, fwd_hit_d;
    head_ram_data_t fwd_data_q, fwd_data_d;

    ht_pdata_t        skid_q [SKID_DEPTH];
    ht_pdata_t        skid_d [SKID_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                    run, wr_en, in_fire, pop, push;
    logic [CNT_W:0]          occ;
    head_ram_data_t          wr_data, s1_head, ram_rd_data, ram_wdata;
    logic                    ram_we;
    logic [BUCKET_WIDTH-1:0] ram_waddr;

    // ---------------- control / flow ----------------
    always_comb begin
        run     = (state_q == ST_RUN) && !rst_i;
        wr_en   = run && head_wr_en_i;
        wr_data = '{ptr: head_wr_ptr_i, val: head_wr_ptr_val_i};
        pop     = (cnt_q != '0) && pdata_out_ready_i;
        // occupancy net of this cycle's pop keeps 1/cycle with SKID_DEPTH=2
        occ     = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(s1_vld_q) - (CNT_W+1)'(pop);
        pdata_in_ready_o  = run && (occ < (CNT_W+1)'(SKID_DEPTH));
        in_fire           = pdata_in_valid_i && pdata_in_ready_o;
        pdata_out_valid_o = (cnt_q != '0);
        pdata_out_o       = skid_q[rd_ptr_q];
        init_done_o       = (state_q == ST_RUN);
    end

    // ---------------- FSM + RAM write port ----------------
    always_comb begin
        state_d   = state_q;
        ram_we    = wr_en;
        ram_waddr = head_wr_addr_i;
        ram_wdata = wr_data;
`ifdef HT_HEAD_TABLE_INIT_EN
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            ram_we     = 1'b1;
            ram_waddr  = init_cnt_q;
            ram_wdata  = '0;
            init_cnt_d = init_cnt_q + BUCKET_WIDTH'(1);
            if (&init_cnt_q) begin
                state_d = ST_RUN;
            end
        end
`else
        if (state_q == ST_INIT) begin
            state_d = ST_RUN;
        end
`endif
    end

    head_table_ram u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (ram_we),
        .wr_addr_i (ram_waddr),
        .wr_data_i (ram_wdata),
        .rd_addr_i (pdata_in_i.bucket),
        .rd_data_o (ram_rd_data)
    );

    // ---------------- read pipeline + skid buffer ----------------
    always_comb begin
        s1_vld_d   = in_fire;
        s1_pdata_d = in_fire ? pdata_in_i : s1_pdata_q;
        fwd_hit_d  = wr_en && (head_wr_addr_i == pdata_in_i.bucket);
        fwd_data_d = wr_data;

        // newest source wins: write this cycle, then issue-cycle write, then RAM
        s1_head = fwd_hit_q ? fwd_data_q : ram_rd_data;
        if (wr_en && (head_wr_addr_i == s1_pdata_q.bucket)) begin
            s1_head = wr_data;
        end
        push = s1_vld_q;

        skid_d = skid_q;
        for (int i = 0; i < SKID_DEPTH; i++) begin
            if (wr_en && (skid_q[i].bucket == head_wr_addr_i)) begin
                skid_d[i].head_ptr     = head_wr_ptr_i;
                skid_d[i].head_ptr_val = head_wr_ptr_val_i;
            end
        end
        if (push) begin
            skid_d[wr_ptr_q] = ht_attach_head(s1_pdata_q, s1_head);
        end

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
`ifdef HT_HEAD_TABLE_INIT_EN
            init_cnt_q <= '0;
`endif
            s1_vld_q   <= 1'b0;
            fwd_hit_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
`ifdef HT_HEAD_TABLE_INIT_EN
            init_cnt_q <= init_cnt_d;
`endif
            s1_vld_q   <= s1_vld_d;
            fwd_hit_q  <= fwd_hit_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // payload registers are qualified by the valid/count state above
    always_ff @(posedge clk_i) begin
        s1_pdata_q <= s1_pdata_d;
        fwd_data_q <= fwd_data_d;
        skid_q     <= skid_d;
    end

endmodule
